// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: blank pattern, active-low hex glyph table and
// capture FSM states, used by both the display driver and the capture front end.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low, bit0=a ... bit6=g; index is the hex value shown.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic {
    WAIT_LO = 1'b0,
    WAIT_HI = 1'b1
  } cap_state_t;

  function automatic logic [6:0] seg_glyph(input logic [3:0] nibble);
    return SEG_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational 7-segment pattern to hex nibble decoder; legal is low for any
// pattern that is not one of the sixteen glyphs (including blank).
module seg_decoder
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] nibble
);

  logic [15:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_match
      assign hit[gi] = (seg == SEG_GLYPH[gi]);
    end
  endgenerate

  // Glyphs are unique, so at most one hit bit is ever set.
  always_comb begin
    legal  = |hit;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (hit[i]) nibble = 4'(i);
    end
  end

endmodule

// File: rtl/seg_mux_capture.sv
// Receive end of a multiplexed dual-digit 7-segment bus: synchronize, wait for
// each digit to settle, decode, and reassemble {hi,lo} frames.
module seg_mux_capture
  import seg_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       toggle_in,
  output logic [7:0] s_out,
  output logic       s_valid,
  output logic       digit_err
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [7:0] SYNC_RST = {1'b0, SEG_BLANK};

  logic [7:0]    sync_reg [SYNC_STAGES];
  logic [7:0]    prev_reg;
  logic [CW-1:0] cnt_reg;
  cap_state_t    state_reg, state_next;
  logic [3:0]    lo_reg, lo_next;
  logic [7:0]    s_out_next;
  logic          s_valid_next, digit_err_next;

  logic [7:0]    cur;
  logic          stable, settle, legal;
  logic [3:0]    nibble;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync_reg[gi] <= SYNC_RST;
        end else if (gi == 0) begin
          sync_reg[gi] <= {toggle_in, seg_in};
        end else begin
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign cur    = sync_reg[SYNC_STAGES-1];
  assign stable = (cur == prev_reg);
  // Fires once per stable run, in the cycle the counter reaches saturation.
  assign settle = stable && (cnt_reg == CW'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_reg <= SYNC_RST;
      cnt_reg  <= '0;
    end else begin
      prev_reg <= cur;
      if (!stable) begin
        cnt_reg <= '0;
      end else if (cnt_reg != CW'(SETTLE_CYCLES)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  seg_decoder u_dec (
    .seg    (cur[6:0]),
    .legal  (legal),
    .nibble (nibble)
  );

  always_comb begin
    state_next     = state_reg;
    lo_next        = lo_reg;
    s_out_next     = s_out;
    s_valid_next   = 1'b0;
    digit_err_next = 1'b0;
    if (settle) begin
      if (!legal) begin
        digit_err_next = 1'b1;
        state_next     = WAIT_LO;
      end else begin
        case (state_reg)
          WAIT_LO: begin
            if (!cur[7]) begin
              lo_next    = nibble;
              state_next = WAIT_HI;
            end
          end
          WAIT_HI: begin
            if (!cur[7]) begin
              lo_next = nibble;
            end else begin
              s_out_next   = {nibble, lo_reg};
              s_valid_next = 1'b1;
              state_next   = WAIT_LO;
            end
          end
          default: state_next = WAIT_LO;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= WAIT_LO;
      lo_reg    <= 4'h0;
      s_out     <= 8'h00;
      s_valid   <= 1'b0;
      digit_err <= 1'b0;
    end else begin
      state_reg <= state_next;
      lo_reg    <= lo_next;
      s_out     <= s_out_next;
      s_valid   <= s_valid_next;
      digit_err <= digit_err_next;
    end
  end

endmodule

// File: tb/tb_seg_mux_capture.sv
// Directed bench for seg_mux_capture: frame capture, latency, glitch rejection,
// illegal glyphs, out-of-order digits and mid-frame reset.
module tb_seg_mux_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] seg_in = 7'h00;
  logic       toggle_in = 1'b0;
  logic [7:0] s_out;
  logic       s_valid;
  logic       digit_err;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int v0, e0;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                         G9 = 7'b0010000, GA = 7'b0001000, GC = 7'b1000110,
                         GF = 7'b0001110, BLANK = 7'h7F;

  seg_mux_capture #(.SYNC_STAGES(2), .SETTLE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .toggle_in (toggle_in),
    .s_out     (s_out),
    .s_valid   (s_valid),
    .digit_err (digit_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (s_valid) valid_cnt++;
    if (digit_err) err_cnt++;
    if (s_valid && digit_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [6:0] seg, input logic t, input int n);
    seg_in    = seg;
    toggle_in = t;
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    v0 = valid_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    // 1: reset held low with an all-on bus
    repeat (3) @(negedge clk);
    chk("rst_s_out", 32'(s_out), 32'h00);
    chk("rst_s_valid", 32'(s_valid), 32'h0);
    chk("rst_digit_err", 32'(digit_err), 32'h0);
    reset = 1'b1;

    // 2: lo '3' then hi 'A', exact latency of the s_valid pulse
    snap();
    hold(G3, 1'b0, 10);
    seg_in    = GA;
    toggle_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("lat_quiet_%0d", k - 1), 32'(s_valid), 32'h0);
    end
    @(negedge clk);
    chk("lat_pulse", 32'(s_valid), 32'h1);
    chk("lat_s_out", 32'(s_out), 32'hA3);
    @(negedge clk);
    chk("lat_one_cycle", 32'(s_valid), 32'h0);
    repeat (2) @(negedge clk);
    chk("t2_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    chk("t2_err_cnt", 32'(err_cnt - e0), 32'd0);

    // 3: short legal-glyph glitch on the lo digit is filtered out
    snap();
    hold(G5, 1'b0, 8);
    hold(G8, 1'b0, 2);
    hold(G5, 1'b0, 8);
    hold(GC, 1'b1, 10);
    chk("t3_s_out", 32'(s_out), 32'hC5);
    chk("t3_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    chk("t3_err_cnt", 32'(err_cnt - e0), 32'd0);

    // 4: blank settles in WAIT_HI -> error, lo discarded; then a clean frame
    snap();
    hold(G6, 1'b0, 8);
    hold(BLANK, 1'b1, 10);
    chk("t4_err_cnt", 32'(err_cnt - e0), 32'd1);
    chk("t4_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("t4_s_out_held", 32'(s_out), 32'hC5);
    snap();
    hold(G1, 1'b0, 10);
    hold(G2, 1'b1, 10);
    chk("t4_s_out", 32'(s_out), 32'h21);
    chk("t4_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    chk("t4_err_after", 32'(err_cnt - e0), 32'd0);

    // 5: hi digit arriving first is ignored
    snap();
    hold(GF, 1'b1, 10);
    hold(G0, 1'b0, 10);
    hold(G7, 1'b1, 10);
    chk("t5_s_out", 32'(s_out), 32'h70);
    chk("t5_valid_cnt", 32'(valid_cnt - v0), 32'd1);

    // 6: reset mid-frame discards the pending lo digit
    snap();
    hold(G9, 1'b0, 10);
    seg_in    = G4;
    toggle_in = 1'b1;
    reset     = 1'b0;
    #1;
    chk("t6_async_s_out", 32'(s_out), 32'h00);
    @(negedge clk);
    reset = 1'b1;
    hold(G4, 1'b1, 12);
    chk("t6_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("t6_no_err", 32'(err_cnt - e0), 32'd0);
    chk("t6_s_out", 32'(s_out), 32'h00);

    chk("never_both", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
